// File: rtl/rv32_prog_loader.sv
// rv32_prog_loader
//
// Byte-stream program loader that feeds the rv32 core's programming ports.
// It accepts framed bytes over a valid/ready handshake. Each frame is a
// command byte, a 16-bit little-endian word count, and then count*4 data
// bytes. Data bytes are packed little-endian into 32-bit words and written
// to instruction or data memory, starting at word address 0. The loader
// also owns the core's active-low reset: the core is held in reset except
// while the loader sits in RUN.
//
// Commands: 0x01 IMEM load, 0x02 DMEM load, 0x03 RUN (no count).
// Any other command byte is an error. The error state is sticky until
// rv32_io_rst.
//
// Ports:
//   rv32_io_clk        clock
//   rv32_io_rst        synchronous active-high reset
//   ld_byte/ld_valid   incoming stream byte and its valid
//   ld_ready           byte accepted this cycle (decoded from state)
//   ld_busy            frame in progress (registered)
//   ld_err             sticky bad-command flag (registered)
//   rv32_io_imem_*     instruction memory write port (registered)
//   rv32_io_dmem_*     data memory write port (registered)
//   rv32_io_program    1 = loader owns the core's dmem write port
//   rv32_io_rst_n      core reset, active-low
module rv32_prog_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              rv32_io_clk,
    input  logic              rv32_io_rst,
    input  logic [7:0]        ld_byte,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_err,
    output logic [ADDR_W-1:0] rv32_io_imem_addr,
    output logic [31:0]       rv32_io_imem_data,
    output logic              rv32_io_imem_w_en,
    output logic [ADDR_W-1:0] rv32_io_dmem_addr,
    output logic [31:0]       rv32_io_dmem_data,
    output logic              rv32_io_dmem_w_en,
    output logic              rv32_io_program,
    output logic              rv32_io_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_RUN,
        S_ERR
    } state_t;

    state_t state;
    state_t next_state;

    logic              accept;
    logic              target_dmem;
    logic [15:0]       cnt;
    logic [15:0]       words_done;
    logic [15:0]       words_done_inc;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       full_word;
    logic              word_done;

    // Next-cycle values of the registered outputs.
    logic wr_imem;
    logic wr_dmem;
    logic busy_next;
    logic err_next;
    logic run_next;

    assign accept         = ld_valid && ld_ready;
    assign words_done_inc = words_done + 16'd1;
    // The 4th byte goes straight from the input into the top of the word.
    // That way the write can be registered on the same edge it is accepted.
    assign full_word      = {ld_byte, word_buf};
    assign word_done      = accept && (state == S_DATA) && (byte_idx == 2'd3);

    // State register.
    always_ff @(posedge rv32_io_clk) begin
        if (rv32_io_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The frame ends on the edge that issues the last write.
    // This lets a new command be accepted on the very next cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (ld_byte)
                        8'h01, 8'h02: next_state = S_CNT_LO;
                        8'h03:        next_state = S_RUN;
                        default:      next_state = S_ERR;
                    endcase
                end
            end
            S_CNT_LO: begin
                if (accept) next_state = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (accept) begin
                    if ({ld_byte, cnt[7:0]} == 16'd0) next_state = S_IDLE;
                    else                              next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (word_done && (words_done_inc == cnt)) next_state = S_IDLE;
            end
            S_RUN: begin
                if (accept && (ld_byte == 8'h00)) next_state = S_IDLE;
            end
            S_ERR: begin
                next_state = S_ERR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Frame bookkeeping: target, count, byte packing and the word address.
    // The word address wraps naturally at ADDR_W bits, so long loads
    // overwrite from address 0.
    always_ff @(posedge rv32_io_clk) begin
        if (rv32_io_rst) begin
            target_dmem <= 1'b0;
            cnt         <= 16'd0;
            words_done  <= 16'd0;
            byte_idx    <= 2'd0;
            word_buf    <= 24'd0;
            word_addr   <= '0;
        end else if (accept) begin
            case (state)
                S_IDLE: begin
                    if ((ld_byte == 8'h01) || (ld_byte == 8'h02)) begin
                        target_dmem <= (ld_byte == 8'h02);
                    end
                end
                S_CNT_LO: begin
                    cnt[7:0] <= ld_byte;
                end
                S_CNT_HI: begin
                    cnt[15:8]  <= ld_byte;
                    words_done <= 16'd0;
                    byte_idx   <= 2'd0;
                    word_addr  <= '0;
                end
                S_DATA: begin
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_buf[7:0]   <= ld_byte;
                        2'd1: word_buf[15:8]  <= ld_byte;
                        2'd2: word_buf[23:16] <= ld_byte;
                        default: begin
                            word_addr  <= word_addr + 1'b1;
                            words_done <= words_done_inc;
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. The flags follow the next state, so the registered
    // outputs describe the state the loader is entering.
    always_comb begin
        ld_ready  = (state != S_ERR);
        wr_imem   = word_done && !target_dmem;
        wr_dmem   = word_done && target_dmem;
        busy_next = (next_state == S_CNT_LO) || (next_state == S_CNT_HI) ||
                    (next_state == S_DATA);
        err_next  = (next_state == S_ERR);
        run_next  = (next_state == S_RUN);
    end

    // Output registers. Address and data only change when their strobe fires.
    // They hold between writes.
    always_ff @(posedge rv32_io_clk) begin
        if (rv32_io_rst) begin
            rv32_io_imem_addr <= '0;
            rv32_io_imem_data <= 32'd0;
            rv32_io_imem_w_en <= 1'b0;
            rv32_io_dmem_addr <= '0;
            rv32_io_dmem_data <= 32'd0;
            rv32_io_dmem_w_en <= 1'b0;
            ld_busy           <= 1'b0;
            ld_err            <= 1'b0;
            rv32_io_program   <= 1'b1;
            rv32_io_rst_n     <= 1'b0;
        end else begin
            rv32_io_imem_w_en <= wr_imem;
            rv32_io_dmem_w_en <= wr_dmem;
            if (wr_imem) begin
                rv32_io_imem_addr <= word_addr;
                rv32_io_imem_data <= full_word;
            end
            if (wr_dmem) begin
                rv32_io_dmem_addr <= word_addr;
                rv32_io_dmem_data <= full_word;
            end
            ld_busy         <= busy_next;
            ld_err          <= err_next;
            rv32_io_program <= !run_next;
            rv32_io_rst_n   <= run_next;
        end
    end

endmodule

// File: tb/tb_rv32_prog_loader.sv
// tb_rv32_prog_loader
//
// Self-checking bench for rv32_prog_loader. A table of byte vectors covers
// the basic frames, RUN entry and RUN exit. Each entry carries the status
// flags expected after its handshake, plus any memory write it should cause.
// Expected writes go onto a scoreboard queue when the byte is driven. A
// monitor pops and compares an entry on every strobe cycle. Hand-written
// sequences cover these cases:
//   - the error state
//   - a 4097-word wrap-around load with random valid gaps
//   - a reset that aborts a frame
module tb_rv32_prog_loader;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst;
    logic [7:0]        ld_byte;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_w_en;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_data;
    logic              dmem_w_en;
    logic              program_sel;
    logic              core_rst_n;

    rv32_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .rv32_io_clk       (clk),
        .rv32_io_rst       (rst),
        .ld_byte           (ld_byte),
        .ld_valid          (ld_valid),
        .ld_ready          (ld_ready),
        .ld_busy           (ld_busy),
        .ld_err            (ld_err),
        .rv32_io_imem_addr (imem_addr),
        .rv32_io_imem_data (imem_data),
        .rv32_io_imem_w_en (imem_w_en),
        .rv32_io_dmem_addr (dmem_addr),
        .rv32_io_dmem_data (dmem_data),
        .rv32_io_dmem_w_en (dmem_w_en),
        .rv32_io_program   (program_sel),
        .rv32_io_rst_n     (core_rst_n)
    );

    typedef struct {
        logic [7:0]  b;
        logic        busy;
        logic        run;
        logic        wr;
        logic        dm;
        logic [11:0] addr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic        dm;
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    vec_t vecs[$];
    wr_t  sbq[$];

    int check_count = 0;
    int pass_count  = 0;
    int writes_seen = 0;
    int cyc         = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] word_val(input int i);
        logic [15:0] idx;
        idx = i[15:0];
        return {idx ^ 16'h5A5A, ~idx};
    endfunction

    // Scoreboard monitor. Every strobe cycle must match the oldest expected
    // write, including the cycle in which it appears.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (imem_w_en || dmem_w_en) begin
            writes_seen++;
            if (sbq.size() == 0) begin
                checkOutput("unexpected_strobe", {30'd0, imem_w_en, dmem_w_en}, 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("wr_target", {30'd0, imem_w_en, dmem_w_en},
                            e.dm ? 32'd1 : 32'd2);
                checkOutput("wr_addr", {20'd0, e.dm ? dmem_addr : imem_addr},
                            {20'd0, e.addr});
                checkOutput("wr_data", e.dm ? dmem_data : imem_data, e.data);
                checkOutput("wr_cycle", cyc, e.cyc);
                checkOutput("wr_program", {31'd0, program_sel}, 32'd1);
                checkOutput("wr_core_rst_n", {31'd0, core_rst_n}, 32'd0);
            end
        end
    end

    // Drives one byte, starting at a negedge, and returns at the negedge
    // after its handshake. ld_valid is left high so bytes can go back-to-back.
    task automatic send_byte(input logic [7:0] b, input logic wr, input logic dm,
                             input logic [11:0] a, input logic [31:0] d);
        int wait_cnt;
        wait_cnt = 0;
        ld_byte  = b;
        ld_valid = 1'b1;
        while (!ld_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!ld_ready) begin
            checkOutput("ready_timeout", {31'd0, ld_ready}, 32'd1);
            ld_valid = 1'b0;
            return;
        end
        if (wr) sbq.push_back('{dm, a, d, cyc + 1});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        ld_valid = 1'b0;
        repeat (n) begin
            ld_byte = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values();
        checkOutput("rst_ready",     {31'd0, ld_ready},    32'd1);
        checkOutput("rst_busy",      {31'd0, ld_busy},     32'd0);
        checkOutput("rst_err",       {31'd0, ld_err},      32'd0);
        checkOutput("rst_program",   {31'd0, program_sel}, 32'd1);
        checkOutput("rst_core_rstn", {31'd0, core_rst_n},  32'd0);
        checkOutput("rst_imem_addr", {20'd0, imem_addr},   32'd0);
        checkOutput("rst_imem_data", imem_data,            32'd0);
        checkOutput("rst_imem_wen",  {31'd0, imem_w_en},   32'd0);
        checkOutput("rst_dmem_addr", {20'd0, dmem_addr},   32'd0);
        checkOutput("rst_dmem_data", dmem_data,            32'd0);
        checkOutput("rst_dmem_wen",  {31'd0, dmem_w_en},   32'd0);
    endtask

    // Applies one reset cycle starting at a negedge. The reset values are
    // checked before reset is released.
    task automatic apply_reset();
        rst      = 1'b1;
        ld_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic [7:0] b, input logic busy, input logic run,
                           input logic wr, input logic dm, input logic [11:0] a,
                           input logic [31:0] d);
        vecs.push_back('{b, busy, run, wr, dm, a, d});
    endtask

    task automatic applyStimulus();
        foreach (vecs[i]) begin
            send_byte(vecs[i].b, vecs[i].wr, vecs[i].dm, vecs[i].addr, vecs[i].data);
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, ld_busy}, {31'd0, vecs[i].busy});
            checkOutput($sformatf("vec%0d_err", i), {31'd0, ld_err}, 32'd0);
            checkOutput($sformatf("vec%0d_ready", i), {31'd0, ld_ready}, 32'd1);
            checkOutput($sformatf("vec%0d_program", i), {31'd0, program_sel},
                        {31'd0, !vecs[i].run});
            checkOutput($sformatf("vec%0d_core_rstn", i), {31'd0, core_rst_n},
                        {31'd0, vecs[i].run});
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        int total_words;
        logic [31:0] w;
        logic [7:0]  bt;
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        @(negedge clk);
        apply_reset();

        // IMEM frame with two words.
        add_vec(8'h01, 1, 0, 0, 0, 0, 0);
        add_vec(8'h02, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 1, 0, 0, 0, 0, 0);
        add_vec(8'h13, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 1, 0, 1, 0, 12'd0, 32'h0000_0013);
        add_vec(8'h93, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 1, 0, 0, 0, 0, 0);
        add_vec(8'h10, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 0, 0, 1, 0, 12'd1, 32'h0010_0093);
        // DMEM frame with one word, then RUN.
        add_vec(8'h02, 1, 0, 0, 0, 0, 0);
        add_vec(8'h01, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 1, 0, 0, 0, 0, 0);
        add_vec(8'hEF, 1, 0, 0, 0, 0, 0);
        add_vec(8'hBE, 1, 0, 0, 0, 0, 0);
        add_vec(8'hAD, 1, 0, 0, 0, 0, 0);
        add_vec(8'hDE, 0, 0, 1, 1, 12'd0, 32'hDEAD_BEEF);
        add_vec(8'h03, 0, 1, 0, 0, 0, 0);
        add_vec(8'h00, 0, 0, 0, 0, 0, 0);
        // Zero-count frame, RUN, ignored byte, then RUN exit.
        add_vec(8'h01, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 1, 0, 0, 0, 0, 0);
        add_vec(8'h00, 0, 0, 0, 0, 0, 0);
        add_vec(8'h03, 0, 1, 0, 0, 0, 0);
        add_vec(8'h55, 0, 1, 0, 0, 0, 0);
        add_vec(8'h00, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        idle_cycles(3);
        checkOutput("table_sb_empty", sbq.size(), 32'd0);

        // A bad command locks the loader until reset.
        send_byte(8'h07, 0, 0, 0, 0);
        checkOutput("err_flag", {31'd0, ld_err}, 32'd1);
        checkOutput("err_ready", {31'd0, ld_ready}, 32'd0);
        checkOutput("err_busy", {31'd0, ld_busy}, 32'd0);
        ld_byte  = 8'h01;
        ld_valid = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("err_sticky", {31'd0, ld_err}, 32'd1);
        checkOutput("err_ready_held", {31'd0, ld_ready}, 32'd0);
        apply_reset();
        send_byte(8'h01, 0, 0, 0, 0);
        checkOutput("post_err_busy", {31'd0, ld_busy}, 32'd1);
        checkOutput("post_err_ready", {31'd0, ld_ready}, 32'd1);
        apply_reset();

        // 4097-word IMEM load with random valid gaps. The last word wraps
        // to address 0.
        total_words = 4097;
        send_byte(8'h01, 0, 0, 0, 0);
        if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 3));
        send_byte(8'h01, 0, 0, 0, 0);
        send_byte(8'h10, 0, 0, 0, 0);
        checkOutput("wrap_busy_start", {31'd0, ld_busy}, 32'd1);
        for (int i = 0; i < total_words; i++) begin
            w = word_val(i);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
                bt = w[8*k +: 8];
                send_byte(bt, k == 3, 0, 12'(i), w);
            end
            if (i == total_words - 2) begin
                checkOutput("wrap_busy_mid", {31'd0, ld_busy}, 32'd1);
            end
        end
        checkOutput("wrap_busy_end", {31'd0, ld_busy}, 32'd0);
        checkOutput("wrap_last_addr", {20'd0, imem_addr}, 32'd0);
        checkOutput("wrap_last_data", imem_data, word_val(4096));
        // A command on the very next cycle after the final write is accepted.
        send_byte(8'h03, 0, 0, 0, 0);
        checkOutput("b2b_run_rstn", {31'd0, core_rst_n}, 32'd1);
        checkOutput("b2b_run_program", {31'd0, program_sel}, 32'd0);
        send_byte(8'h00, 0, 0, 0, 0);
        checkOutput("run_exit_rstn", {31'd0, core_rst_n}, 32'd0);
        idle_cycles(2);
        checkOutput("wrap_sb_empty", sbq.size(), 32'd0);

        // A reset after 2 data bytes aborts the frame without a strobe.
        send_byte(8'h01, 0, 0, 0, 0);
        send_byte(8'h01, 0, 0, 0, 0);
        send_byte(8'h10, 0, 0, 0, 0);
        send_byte(8'hAA, 0, 0, 0, 0);
        send_byte(8'hBB, 0, 0, 0, 0);
        apply_reset();
        idle_cycles(8);
        checkOutput("abort_sb_empty", sbq.size(), 32'd0);
        checkOutput("writes_total", writes_seen, 32'd4100);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
